prover_compute_w0_multi: RTL and testbench
==========================================

# prover_compute_w0_multi

Multi-lane, order-selectable successor to the single-lane w0 evaluator used between sumcheck rounds of the prover. Given per-input-bit line endpoints w1[i] and w2_m_w1[i] = w2[i] − w1[i], plus a challenge tau, it computes w0[i] = w1[i] + tau·w2_m_w1[i] mod F_Q and m_w0_p1[i] = 1 − w0[i] mod F_Q. Results stream out in groups of nlanes with a ready/cont handshake to the downstream V-table/beta update logic.

## Interface
- ninbits, default 8: number of input-bit coordinates (vector length), ≥1.
- nlanes, default 2: coordinates computed in parallel per group, 1 ≤ nlanes ≤ ninbits; need not divide ninbits.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  start pulse; sampled only in IDLE.
- cont  in  1  consumer acknowledge of the current output group.
- mode  in  1  output order, latched with en: 0 = descending (ninbits−1 first), 1 = ascending (0 first).
- w1  in  ninbits×F_NBITS  line start points; latched on accepted en.
- w2_m_w1  in  ninbits×F_NBITS  line directions; latched on accepted en.
- tau  in  F_NBITS  challenge; latched on accepted en.
- ready  out  1  high in IDLE (idle, able to accept en).
- w0_ready  out  1  current group valid on w0/m_w0_p1/lane_valid/idx.
- w0  out  nlanes×F_NBITS  w0 for lanes of current group.
- m_w0_p1  out  nlanes×F_NBITS  1 − w0 per lane.
- lane_valid  out  nlanes  lane k carries a real coordinate.
- idx  out  clog2(ninbits)  coordinate index carried by lane 0.

## Operation
- States: IDLE → MUL → ADD → HOLD → (MUL | IDLE).
- IDLE: ready=1. en=1 latches w1, w2_m_w1, tau, mode; sets group pointer to first group; → MUL. en outside IDLE ignored.
- Groups: ngroups = ceil(ninbits/nlanes). Descending: group g covers idx = ninbits−1−g·nlanes down by one per lane; ascending: idx = g·nlanes up by one per lane. Lane k of a partial last group beyond the vector has lane_valid[k]=0, w0 and m_w0_p1 = 0.
- MUL: pulse en to every valid lane multiplier for tau·w2_m_w1[idx_k]; wait until all valid lanes report ready; → ADD.
- ADD: w0 = (prod + w1) mod F_Q (single conditional subtract); m_w0_p1 = (~w0 + F_Q_P2_MI) mod F_Q; register outputs; → HOLD.
- HOLD: w0_ready=1, outputs stable. cont=1 sampled → w0_ready drops next cycle; if more groups → MUL with next group, else → IDLE.
- cont outside HOLD ignored. No overlap of next group's multiply with HOLD.
- Inputs must be reduced (< F_Q); unreduced inputs give undefined results.
- rst in any state: → IDLE next edge; ready=1, w0_ready=0, w0=0, m_w0_p1=0, lane_valid=0, idx=0; in-flight multiplies discarded (multipliers reset).

## Timing
- Cycle 0 en accepted; cycle 1 MUL launches; L = multiplier latency (cycles from en to ready); ADD at 1+L; w0_ready high from cycle 2+L.
- Per group, cont-to-next-w0_ready = L+2 cycles. Total with cont held high: ngroups·(L+2) + 1 cycles to return to ready.
- ready falls the cycle after en, rises the cycle after final cont.
- en and cont in the same cycle in HOLD: cont honoured, en ignored.

## Structure
- F_NBITS, F_Q, F_Q_P2_MI from the shared field-arithmetic header; no new constants.
- State enum local to the module.
- Sub-module prover_w0_lane: one field_multiplier instance, the mod-add, and the 1 − x computation; instantiated nlanes times in a generate loop. Top holds FSM, group pointer, index/order logic, input latches.

## Test plan
- ninbits=8, nlanes=2, mode=0, random reduced inputs, cont echoed from w0_ready -> 4 groups, idx 7,5,3,1, each lane matches reference model; ready returns after last cont.
- Same with mode=1 -> idx 0,2,4,6, identical per-index values.
- ninbits=5, nlanes=2 -> 3 groups; last has lane_valid=2'b01, lane 1 outputs 0.
- tau=0 -> w0=w1, m_w0_p1=1−w1; w1=F_Q−1, w2_m_w1=1, tau=1 -> w0=0, m_w0_p1=1; w1=0, tau=0 -> m_w0_p1=1.
- cont held low 20 cycles in HOLD -> outputs stable, w0_ready stays 1; en pulses mid-run ignored.
- rst asserted during MUL of group 2 -> next cycle ready=1, w0_ready=0, outputs 0; fresh en runs full correct sequence.

Source files
------------

// File: rtl/prover_compute_w0_multi_pkg.sv
// rtl/prover_compute_w0_multi_pkg.sv - shared field constants and modular reduction helper
//
// Purpose: field width, modulus and the complement offset used to form 1 - x,
// plus a reduction helper shared by the multiplier and the lane datapath.
// Ports: none (package).
package prover_compute_w0_multi_pkg;

  localparam int F_NBITS = 16;
  localparam logic [F_NBITS-1:0] F_Q = 16'd65521;
  // Congruent to 2 - 2^F_NBITS mod F_Q, so (~x + F_Q_P2_MI) == 1 - x (mod F_Q).
  localparam logic [F_NBITS-1:0] F_Q_P2_MI = 16'd65508;

  // Reduces any x < 3*F_Q into [0, F_Q).
  function automatic logic [F_NBITS-1:0] mod_reduce(input logic [F_NBITS+1:0] x);
    logic [F_NBITS+1:0] t;
    t = x;
    if (t >= {2'b00, F_Q}) t = t - {2'b00, F_Q};
    if (t >= {2'b00, F_Q}) t = t - {2'b00, F_Q};
    return t[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/field_multiplier.sv
// rtl/field_multiplier.sv - iterative MSB-first double-and-add modular multiplier
//
// Purpose: prod = a * b mod F_Q, one bit of b per cycle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          start pulse; latches a and b, clears the accumulator
//   a, b        reduced operands
//   ready       one-cycle pulse when prod holds the finished product
//   prod        product; stays stable until the next en
module field_multiplier
  import prover_compute_w0_multi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic               ready,
  output logic [F_NBITS-1:0] prod
);

  localparam int CW = $clog2(F_NBITS + 1);

  logic [F_NBITS-1:0] a_q;
  logic [F_NBITS-1:0] b_q;
  logic [CW-1:0]      cnt;
  logic [F_NBITS-1:0] dbl;
  logic [F_NBITS-1:0] step;

  // acc <- 2*acc + b_msb*a, each partial kept reduced so both sums stay < 2*F_Q.
  always_comb begin
    dbl  = mod_reduce({1'b0, prod, 1'b0});
    step = mod_reduce({2'b00, dbl} + (b_q[F_NBITS-1] ? {2'b00, a_q} : '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      ready <= 1'b0;
      prod  <= '0;
    end else begin
      ready <= 1'b0;
      if (en) begin
        a_q  <= a;
        b_q  <= b;
        cnt  <= CW'(F_NBITS);
        prod <= '0;
      end else if (cnt != '0) begin
        prod <= step;
        b_q  <= b_q << 1;
        cnt  <= cnt - 1'b1;
        if (cnt == CW'(1)) ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prover_w0_lane.sv
// rtl/prover_w0_lane.sv - one w0 lane: tau*dir multiply, add start point, form 1 - w0
//
// Purpose: w0 = w1 + tau*w2_m_w1 mod F_Q and m_w0_p1 = 1 - w0 mod F_Q.
// Ports:
//   clk, rst    clock, synchronous active-high reset (also resets the multiplier)
//   en          multiply launch pulse
//   load        register w0/m_w0_p1 from the current product
//   valid       lane carries a real coordinate; invalid lanes load zeros
//   tau, w1, w2_m_w1   operands for this lane
//   ready       multiplier done pulse
//   w0, m_w0_p1 registered results
module prover_w0_lane
  import prover_compute_w0_multi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic               valid,
  input  logic [F_NBITS-1:0] tau,
  input  logic [F_NBITS-1:0] w1,
  input  logic [F_NBITS-1:0] w2_m_w1,
  output logic               ready,
  output logic [F_NBITS-1:0] w0,
  output logic [F_NBITS-1:0] m_w0_p1
);

  logic [F_NBITS-1:0] prod;
  logic [F_NBITS-1:0] w0_next;
  logic [F_NBITS-1:0] m_next;

  field_multiplier u_mul (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (tau),
    .b     (w2_m_w1),
    .ready (ready),
    .prod  (prod)
  );

  // prod + w1 < 2*F_Q, so only the first subtract in mod_reduce can fire.
  always_comb begin
    w0_next = mod_reduce({2'b00, prod} + {2'b00, w1});
    m_next  = mod_reduce({2'b00, ~w0_next} + {2'b00, F_Q_P2_MI});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w0      <= '0;
      m_w0_p1 <= '0;
    end else if (load) begin
      w0      <= valid ? w0_next : '0;
      m_w0_p1 <= valid ? m_next  : '0;
    end
  end

endmodule

// File: rtl/prover_compute_w0_multi.sv
// rtl/prover_compute_w0_multi.sv - multi-lane w0 / (1 - w0) evaluator with selectable order
//
// Purpose: streams w0[i] and 1 - w0[i] in groups of nlanes, descending or ascending.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  start pulse (IDLE only); latches w1, w2_m_w1, tau, mode
//   cont                consumer acknowledge of the group shown in HOLD
//   mode                0 = descending index order, 1 = ascending
//   w1, w2_m_w1, tau    line endpoints and challenge
//   ready               idle, can accept en
//   w0_ready            group outputs valid
//   w0, m_w0_p1         per-lane results
//   lane_valid          per-lane real-coordinate flags
//   idx                 coordinate index on lane 0
module prover_compute_w0_multi
  import prover_compute_w0_multi_pkg::*;
#(
  parameter int ninbits = 8,
  parameter int nlanes  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 cont,
  input  logic                                 mode,
  input  logic [ninbits-1:0][F_NBITS-1:0]      w1,
  input  logic [ninbits-1:0][F_NBITS-1:0]      w2_m_w1,
  input  logic [F_NBITS-1:0]                   tau,
  output logic                                 ready,
  output logic                                 w0_ready,
  output logic [nlanes-1:0][F_NBITS-1:0]       w0,
  output logic [nlanes-1:0][F_NBITS-1:0]       m_w0_p1,
  output logic [nlanes-1:0]                    lane_valid,
  output logic [((ninbits > 1) ? $clog2(ninbits) : 1)-1:0] idx
);

  localparam int IDX_W   = (ninbits > 1) ? $clog2(ninbits) : 1;
  localparam int NGROUPS = (ninbits + nlanes - 1) / nlanes;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_HOLD} state_t;

  state_t state, next_state;
  logic   launch;
  logic   mul_start;
  logic   load;
  logic   last_group;
  logic   all_ready;
  logic   mode_q;
  logic [GW-1:0]                    group;
  logic [ninbits-1:0][F_NBITS-1:0]  w1_q;
  logic [ninbits-1:0][F_NBITS-1:0]  w2_q;
  logic [F_NBITS-1:0]               tau_q;
  logic [nlanes-1:0]                grp_valid;
  logic [nlanes-1:0]                lane_ready;
  logic [nlanes-1:0][IDX_W-1:0]     lane_idx;
  logic [nlanes-1:0][F_NBITS-1:0]   lane_w1;
  logic [nlanes-1:0][F_NBITS-1:0]   lane_w2;

  // Lane k of group g sits at position g*nlanes+k counted from the first
  // coordinate emitted; order only changes how position maps to index.
  always_comb begin
    int pos;
    int sel;
    pos       = 0;
    sel       = 0;
    grp_valid = '0;
    lane_idx  = '0;
    lane_w1   = '0;
    lane_w2   = '0;
    for (int k = 0; k < nlanes; k++) begin
      pos          = int'(group) * nlanes + k;
      grp_valid[k] = (pos < ninbits);
      sel          = grp_valid[k] ? (mode_q ? pos : ninbits - 1 - pos) : 0;
      lane_idx[k]  = IDX_W'(sel);
      lane_w1[k]   = w1_q[lane_idx[k]];
      lane_w2[k]   = w2_q[lane_idx[k]];
    end
  end

  assign last_group = (group == GW'(NGROUPS - 1));
  // Lanes past the end of the vector never launch, so they must not gate progress.
  assign all_ready  = &(lane_ready | ~grp_valid);
  assign ready      = (state == S_IDLE);
  assign w0_ready   = (state == S_HOLD);

  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    load       = 1'b0;
    unique case (state)
      S_IDLE: if (en) next_state = S_MUL;
      S_MUL: begin
        if (launch) mul_start = 1'b1;
        else if (all_ready) next_state = S_ADD;
      end
      S_ADD: begin
        load       = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: if (cont) next_state = last_group ? S_IDLE : S_MUL;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      launch     <= 1'b0;
      group      <= '0;
      mode_q     <= 1'b0;
      w1_q       <= '0;
      w2_q       <= '0;
      tau_q      <= '0;
      lane_valid <= '0;
      idx        <= '0;
    end else begin
      state  <= next_state;
      // First MUL cycle of each group issues the multiply; later cycles wait.
      launch <= (next_state == S_MUL) && (state != S_MUL);
      if (state == S_IDLE && en) begin
        w1_q   <= w1;
        w2_q   <= w2_m_w1;
        tau_q  <= tau;
        mode_q <= mode;
        group  <= '0;
      end
      if (state == S_HOLD && cont && !last_group) group <= group + 1'b1;
      if (load) begin
        lane_valid <= grp_valid;
        idx        <= lane_idx[0];
      end
    end
  end

  for (genvar k = 0; k < nlanes; k++) begin : g_lane
    prover_w0_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (mul_start & grp_valid[k]),
      .load    (load),
      .valid   (grp_valid[k]),
      .tau     (tau_q),
      .w1      (lane_w1[k]),
      .w2_m_w1 (lane_w2[k]),
      .ready   (lane_ready[k]),
      .w0      (w0[k]),
      .m_w0_p1 (m_w0_p1[k])
    );
  end

endmodule

// File: tb/tb_prover_compute_w0_multi.sv
// tb/tb_prover_compute_w0_multi.sv - scoreboard bench for prover_compute_w0_multi
module tb_prover_compute_w0_multi;

  localparam longint Q = 65521;
  localparam int     L = 18;  // MUL-state cycles per group: launch + 16 steps + done

  typedef struct packed {
    logic [2:0]       idx;
    logic [1:0]       lv;
    logic [1:0][15:0] w0;
    logic [1:0][15:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_en = 0, a_cont = 0, a_mode = 0;
  logic [7:0][15:0] a_w1 = '0, a_d = '0;
  logic [15:0] a_tau = '0;
  logic a_ready, a_w0_ready;
  logic [1:0][15:0] a_w0, a_m;
  logic [1:0] a_lv;
  logic [2:0] a_idx;

  logic b_en = 0, b_cont = 0, b_mode = 0;
  logic [4:0][15:0] b_w1 = '0, b_d = '0;
  logic [15:0] b_tau = '0;
  logic b_ready, b_w0_ready;
  logic [1:0][15:0] b_w0, b_m;
  logic [1:0] b_lv;
  logic [2:0] b_idx;

  prover_compute_w0_multi #(.ninbits(8), .nlanes(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .cont(a_cont), .mode(a_mode),
    .w1(a_w1), .w2_m_w1(a_d), .tau(a_tau), .ready(a_ready), .w0_ready(a_w0_ready),
    .w0(a_w0), .m_w0_p1(a_m), .lane_valid(a_lv), .idx(a_idx)
  );

  prover_compute_w0_multi #(.ninbits(5), .nlanes(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .cont(b_cont), .mode(b_mode),
    .w1(b_w1), .w2_m_w1(b_d), .tau(b_tau), .ready(b_ready), .w0_ready(b_w0_ready),
    .w0(b_w0), .m_w0_p1(b_m), .lane_valid(b_lv), .idx(b_idx)
  );

  int n_pass = 0;
  int n_total = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] ref_w0(input logic [15:0] w1, input logic [15:0] d, input logic [15:0] t);
    return 16'((longint'(w1) + longint'(t) * longint'(d)) % Q);
  endfunction

  function automatic logic [15:0] ref_m(input logic [15:0] w0);
    return 16'((1 + Q - longint'(w0)) % Q);
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic w0r(input bit sel);
    return sel ? b_w0_ready : a_w0_ready;
  endfunction

  function automatic logic [15:0] w0l0(input bit sel);
    return sel ? b_w0[0] : a_w0[0];
  endfunction

  task automatic set_en(input bit sel, input logic v);
    if (sel) b_en = v; else a_en = v;
  endtask

  task automatic set_cont(input bit sel, input logic v);
    if (sel) b_cont = v; else a_cont = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_a();
    check("rst_ready", a_ready, 1);
    check("rst_w0_ready", a_w0_ready, 0);
    check("rst_w0", a_w0, 0);
    check("rst_m_w0_p1", a_m, 0);
    check("rst_lane_valid", a_lv, 0);
    check("rst_idx", a_idx, 0);
  endtask

  // One full (or reset-aborted) evaluation on DUT A (sel=0) or B (sel=1).
  task automatic run(input bit sel, input bit md, input logic [7:0][15:0] w1v,
                     input logic [7:0][15:0] dv, input logic [15:0] t,
                     input int stall, input bit noise, input int abort_g);
    int n, ng, c, guard;
    exp_t e;
    logic [15:0] exp_l0 [4];
    n  = sel ? 5 : 8;
    ng = (n + 1) / 2;
    for (int g = 0; g < ng; g++) begin
      e = '0;
      for (int k = 0; k < 2; k++) begin
        int pos, ix;
        pos = g * 2 + k;
        if (pos < n) begin
          ix = md ? pos : n - 1 - pos;
          e.lv[k] = 1'b1;
          e.w0[k] = ref_w0(w1v[ix], dv[ix], t);
          e.m[k]  = ref_m(e.w0[k]);
          if (k == 0) e.idx = 3'(ix);
        end
      end
      exp_l0[g] = e.w0[0];
      if (abort_g < 0 || g < abort_g) begin
        if (sel) qb.push_back(e); else qa.push_back(e);
      end
    end
    @(negedge clk);
    if (sel) begin
      for (int i = 0; i < 5; i++) begin
        b_w1[i] = w1v[i];
        b_d[i]  = dv[i];
      end
      b_tau = t;
      b_mode = md;
    end else begin
      a_w1 = w1v;
      a_d = dv;
      a_tau = t;
      a_mode = md;
    end
    set_en(sel, 1);
    tick();
    set_en(sel, 0);
    c = 1;
    check("ready_fall", rdy(sel), 0);
    for (int g = 0; g < ng; g++) begin
      if (g == abort_g) begin
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        check_reset_a();
        return;
      end
      guard = 0;
      while (!w0r(sel) && guard < 200) begin
        set_en(sel, noise && guard == 2);
        tick();
        c++;
        guard++;
      end
      set_en(sel, 0);
      check("w0_ready_seen", w0r(sel), 1);
      if (!w0r(sel)) return;
      if (g == 0) check("first_latency", c, L + 2);
      for (int s = 0; s < stall; s++) begin
        set_en(sel, noise);
        tick();
        c++;
        check("hold_w0_ready", w0r(sel), 1);
        check("hold_w0_lane0", w0l0(sel), exp_l0[g]);
      end
      set_cont(sel, 1);
      set_en(sel, noise && g == ng - 1);
      tick();
      c++;
      set_cont(sel, 0);
      set_en(sel, 0);
      check("w0_ready_drop", w0r(sel), 0);
    end
    check("ready_return", rdy(sel), 1);
    if (stall == 0) check("total_cycles", c, ng * (L + 2) + 1);
  endtask

  initial begin : mon_a
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_w0_ready && !prev) begin
        if (qa.size() == 0) begin
          n_total++;
          $display("FAIL a_unexpected_group: got idx %0d expected no group", a_idx);
        end else begin
          e = qa.pop_front();
          check("a_idx", a_idx, e.idx);
          check("a_lane_valid", a_lv, e.lv);
          for (int k = 0; k < 2; k++) begin
            check($sformatf("a_w0_lane%0d_idx%0d", k, e.idx), a_w0[k], e.w0[k]);
            check($sformatf("a_m_w0_p1_lane%0d_idx%0d", k, e.idx), a_m[k], e.m[k]);
          end
        end
      end
      prev = a_w0_ready;
    end
  end

  initial begin : mon_b
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_w0_ready && !prev) begin
        if (qb.size() == 0) begin
          n_total++;
          $display("FAIL b_unexpected_group: got idx %0d expected no group", b_idx);
        end else begin
          e = qb.pop_front();
          check("b_idx", b_idx, e.idx);
          check("b_lane_valid", b_lv, e.lv);
          for (int k = 0; k < 2; k++) begin
            check($sformatf("b_w0_lane%0d_idx%0d", k, e.idx), b_w0[k], e.w0[k]);
            check($sformatf("b_m_w0_p1_lane%0d_idx%0d", k, e.idx), b_m[k], e.m[k]);
          end
        end
      end
      prev = b_w0_ready;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0][15:0] v_w1, v_d, e_w1, e_d, f_w1, f_d;
    v_w1 = {16'd4242, 16'd65000, 16'd777, 16'd30000, 16'd1, 16'd0, 16'd65520, 16'd12345};
    v_d  = {16'd31, 16'd40000, 16'd12, 16'd500, 16'd2, 16'd65520, 16'd1, 16'd9999};
    e_w1 = {16'd9, 16'd65520, 16'd100, 16'd0, 16'd2, 16'd65519, 16'd0, 16'd65520};
    e_d  = {16'd3, 16'd60000, 16'd7, 16'd65000, 16'd1, 16'd2, 16'd9, 16'd4};
    f_w1 = {8{16'd65520}};
    f_d  = {8{16'd1}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_reset_a();
    check("b_rst_ready", b_ready, 1);
    check("b_rst_lane_valid", b_lv, 0);

    run(0, 0, v_w1, v_d, 16'd54321, 0, 0, -1);
    run(0, 1, v_w1, v_d, 16'd54321, 0, 0, -1);
    run(1, 0, v_w1, v_d, 16'd54321, 0, 0, -1);
    run(1, 1, v_w1, v_d, 16'd54321, 0, 0, -1);
    run(0, 0, e_w1, e_d, 16'd0, 0, 0, -1);
    run(0, 1, f_w1, f_d, 16'd1, 0, 0, -1);
    run(0, 0, v_w1, v_d, 16'd1234, 20, 1, -1);
    run(0, 0, v_w1, v_d, 16'd54321, 0, 0, 2);
    run(0, 1, v_w1, v_d, 16'd777, 0, 0, -1);

    repeat (3) tick();
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
